// File: rtl/serial_link_pkg.sv
// Shared definitions for the parity-protected serial bit link.
package serial_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Parity bit a transmitter appends so that word+parity carries an odd
  // (odd=1) or even (odd=0) number of ones. Unused upper bits must be zero.
  function automatic logic parity_of(input logic [31:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/serial_parity_rx_parity_acc.sv
// Running XNOR parity accumulator with synchronous load.
module parity_acc #(
  parameter bit INIT_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic en,
  input  logic bit_in,
  output logic acc_out
);

  // Load on init, otherwise fold each enabled bit in with an XNOR step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out <= 1'b0;
    end else if (init) begin
      acc_out <= INIT_VAL;
    end else if (en) begin
      acc_out <= ~(acc_out ^ bit_in);
    end
  end

endmodule

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start, DATA_W bits LSB first, parity, stop.
module serial_parity_rx
  import serial_link_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b1,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_valid,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  rx_state_e         state, next_state;
  logic [BC_W-1:0]   bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] msb_in;
  logic              acc_init;
  logic              acc_en;
  logic              acc_out;
  logic              last_bit;

  assign last_bit = (bit_cnt == BC_W'(DATA_W - 1));
  assign busy     = (state != IDLE);

  // After the parity sample the accumulator holds the final value, so it
  // doubles as the latched parity error until the stop bit is taken.
  parity_acc #(
    .INIT_VAL (~ODD_PARITY)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (acc_init),
    .en      (acc_en),
    .bit_in  (rx_bit),
    .acc_out (acc_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and accumulator control; nothing moves without a strobe.
  always_comb begin
    next_state = state;
    acc_init   = 1'b0;
    acc_en     = 1'b0;
    if (bit_valid) begin
      case (state)
        IDLE: begin
          if (rx_bit == START_BIT) begin
            next_state = DATA;
            acc_init   = 1'b1;
          end
        end
        DATA: begin
          acc_en = 1'b1;
          if (last_bit) next_state = PARITY;
        end
        PARITY: begin
          acc_en     = 1'b1;
          next_state = STOP;
        end
        STOP: begin
          next_state = (rx_bit == STOP_BIT) ? IDLE : BREAK;
        end
        BREAK: begin
          if (rx_bit == STOP_BIT) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Incoming bit positioned at the MSB for the right-shifting deserialiser.
  always_comb begin
    msb_in           = '0;
    msb_in[DATA_W-1] = rx_bit;
  end

  // Deserialiser, bit counter and registered frame results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      data_valid <= 1'b0;
      if (bit_valid) begin
        case (state)
          IDLE: begin
            if (rx_bit == START_BIT) bit_cnt <= '0;
          end
          DATA: begin
            shreg   <= (shreg >> 1) | msb_in;
            bit_cnt <= bit_cnt + BC_W'(1);
          end
          STOP: begin
            data_out   <= shreg;
            data_valid <= 1'b1;
            parity_err <= (acc_out != 1'b0);
            frame_err  <= ~rx_bit;
            if ((acc_out != 1'b0) && (err_cnt != '1)) begin
              err_cnt <= err_cnt + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
